// File: rtl/axis_checksum_appender.sv
// AXI-Stream pass-through that follows every packet with a checksum beat, so the
// modular sum of payload plus checksum is zero; packets reaching max_len are cut short.
module axis_checksum_appender #(
  parameter int width   = 8,
  parameter int max_len = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] S_TData,
  input  logic             S_TValid,
  input  logic             S_TLast,
  output logic             S_TReady,
  output logic [width-1:0] M_TData,
  output logic             M_TValid,
  output logic             M_TLast,
  input  logic             M_TReady,
  output logic [15:0]      pkt_count,
  output logic             err_oversize
);

  localparam int len_w = $clog2(max_len) + 1;
  localparam logic [len_w-1:0] len_max = len_w'(max_len);

  typedef enum logic {PASS, APPEND} state_t;

  state_t           state;
  logic [width-1:0] sum;
  logic [len_w-1:0] len;
  logic [len_w-1:0] len_next;
  logic             out_free;
  logic             in_xfer;
  logic             hit_max;

  // The single output register can take a new beat when empty or being drained now.
  assign out_free = !M_TValid || M_TReady;
  assign S_TReady = (state == PASS) && out_free;
  assign in_xfer  = S_TValid && S_TReady;
  assign len_next = len + len_w'(1);
  assign hit_max  = (len_next == len_max);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= PASS;
      sum          <= '0;
      len          <= '0;
      pkt_count    <= '0;
      M_TData      <= '0;
      M_TValid     <= 1'b0;
      M_TLast      <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      case (state)
        PASS: begin
          if (in_xfer) begin
            M_TData  <= S_TData;
            M_TLast  <= 1'b0;
            M_TValid <= 1'b1;
            sum      <= sum + S_TData;
            len      <= len_next;
            if (S_TLast || hit_max) begin
              state <= APPEND;
            end
            if (!S_TLast && hit_max) begin
              err_oversize <= 1'b1;
            end
          end else if (out_free) begin
            M_TValid <= 1'b0;
          end
        end
        APPEND: begin
          // Two's-complement negation makes the packet sum wrap to zero.
          if (out_free) begin
            M_TData   <= -sum;
            M_TLast   <= 1'b1;
            M_TValid  <= 1'b1;
            sum       <= '0;
            len       <= '0;
            pkt_count <= pkt_count + 16'd1;
            state     <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_checksum_appender.sv
// Scoreboard bench for axis_checksum_appender (max_len=4): directed packets push
// hand-computed beats into a queue that a negedge monitor pops on each output transfer.
module tb_axis_checksum_appender;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  S_TData;
  logic        S_TValid;
  logic        S_TLast;
  logic        S_TReady;
  logic [7:0]  M_TData;
  logic        M_TValid;
  logic        M_TLast;
  logic        M_TReady;
  logic [15:0] pkt_count;
  logic        err_oversize;

  int checks = 0;
  int passes = 0;
  int err_seen = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pkt[8];

  axis_checksum_appender #(.width(8), .max_len(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .S_TData(S_TData), .S_TValid(S_TValid), .S_TLast(S_TLast), .S_TReady(S_TReady),
    .M_TData(M_TData), .M_TValid(M_TValid), .M_TLast(M_TLast), .M_TReady(M_TReady),
    .pkt_count(pkt_count), .err_oversize(err_oversize)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic expectBeat(input logic [7:0] data, input logic last);
    exp_q.push_back({last, data});
  endtask

  // Sends pkt[0..n-1]; TLast goes on the final beat only when with_last is set.
  task automatic applyStimulus(input int n, input bit with_last);
    bit done;
    int waited;
    for (int i = 0; i < n; i++) begin
      S_TData  = pkt[i];
      S_TValid = 1'b1;
      S_TLast  = with_last && (i == n - 1);
      done   = 1'b0;
      waited = 0;
      while (!done && waited < 20) begin
        @(negedge CLK);
        done = S_TReady;
        @(posedge CLK);
        waited++;
      end
      #1;
      if (!done) begin
        checks++;
        $display("[TB] FAIL send beat %0d: got no S_TReady, expected handshake within 20 cycles", i);
      end
    end
    S_TValid = 1'b0;
    S_TLast  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s drain: got %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  // Monitor: compares each output transfer and checks stalled beats hold steady.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge CLK) begin
    logic [8:0] exp_beat;
    if (Reset) begin
      prev_stall = 1'b0;
    end else begin
      if (err_oversize) err_seen++;
      if (prev_stall && M_TValid) begin
        checkOutput("stall data hold", {24'd0, M_TData}, {24'd0, prev_data});
        checkOutput("stall last hold", {31'd0, M_TLast}, {31'd0, prev_last});
      end
      prev_stall = M_TValid && !M_TReady;
      prev_data  = M_TData;
      prev_last  = M_TLast;
      if (M_TValid && M_TReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected beat: got data 0x%0h last %0b, expected no beat", M_TData, M_TLast);
        end else begin
          exp_beat = exp_q.pop_front();
          checkOutput("beat data", {24'd0, M_TData}, {24'd0, exp_beat[7:0]});
          checkOutput("beat last", {31'd0, M_TLast}, {31'd0, exp_beat[8]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int err_before;
    Reset    = 1'b1;
    S_TData  = 8'h00;
    S_TValid = 1'b0;
    S_TLast  = 1'b0;
    M_TReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    checkOutput("reset S_TReady", {31'd0, S_TReady}, 32'd1);
    checkOutput("reset M_TValid", {31'd0, M_TValid}, 32'd0);
    checkOutput("reset pkt_count", {16'd0, pkt_count}, 32'd0);
    checkOutput("reset err_oversize", {31'd0, err_oversize}, 32'd0);
    @(posedge CLK); #1;

    // Three-beat packet: 1+2+3=6, checksum 0x100-6=0xFA.
    pkt = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expectBeat(8'h01, 1'b0); expectBeat(8'h02, 1'b0); expectBeat(8'h03, 1'b0); expectBeat(8'hFA, 1'b1);
    applyStimulus(3, 1'b1);
    waitDrain("pkt3");
    checkOutput("pkt_count after pkt3", {16'd0, pkt_count}, 32'd1);

    // Single beat 0x80: checksum is 0x80 and input stalls for one cycle only.
    @(posedge CLK); #1;
    pkt[0] = 8'h80;
    expectBeat(8'h80, 1'b0); expectBeat(8'h80, 1'b1);
    applyStimulus(1, 1'b1);
    @(negedge CLK);
    checkOutput("single S_TReady low", {31'd0, S_TReady}, 32'd0);
    @(negedge CLK);
    checkOutput("single S_TReady back", {31'd0, S_TReady}, 32'd1);
    waitDrain("single");
    checkOutput("pkt_count after single", {16'd0, pkt_count}, 32'd2);

    // Four beats with M_TReady 1,0,0,1: sum 0xAA, checksum 0x56; len hits max_len with TLast, so no error.
    @(posedge CLK); #1;
    err_before = err_seen;
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    expectBeat(8'h11, 1'b0); expectBeat(8'h22, 1'b0); expectBeat(8'h33, 1'b0); expectBeat(8'h44, 1'b0);
    expectBeat(8'h56, 1'b1);
    fork
      applyStimulus(4, 1'b1);
      begin
        M_TReady = 1'b1; @(posedge CLK); #1;
        M_TReady = 1'b0; @(posedge CLK); #1;
        M_TReady = 1'b0; @(posedge CLK); #1;
        M_TReady = 1'b1;
      end
    join
    waitDrain("stall");
    checkOutput("pkt_count after stall", {16'd0, pkt_count}, 32'd3);
    checkOutput("no err on exact max_len", err_seen - err_before, 32'd0);

    // Six beats with max_len=4: cut after 0x13 (checksum 0xBA), remainder 0x14,0x15 (checksum 0xD7).
    @(posedge CLK); #1;
    err_before = err_seen;
    pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
    expectBeat(8'h10, 1'b0); expectBeat(8'h11, 1'b0); expectBeat(8'h12, 1'b0); expectBeat(8'h13, 1'b0);
    expectBeat(8'hBA, 1'b1);
    expectBeat(8'h14, 1'b0); expectBeat(8'h15, 1'b0); expectBeat(8'hD7, 1'b1);
    applyStimulus(6, 1'b1);
    waitDrain("oversize");
    checkOutput("oversize err pulses", err_seen - err_before, 32'd1);
    checkOutput("pkt_count after oversize", {16'd0, pkt_count}, 32'd5);

    // Reset mid-packet: partial packet dropped, next packet 0xFF gets checksum 0x01.
    @(posedge CLK); #1;
    pkt[0] = 8'h05; pkt[1] = 8'h06;
    expectBeat(8'h05, 1'b0); expectBeat(8'h06, 1'b0);
    applyStimulus(2, 1'b0);
    @(negedge CLK);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("mid-reset M_TValid", {31'd0, M_TValid}, 32'd0);
    checkOutput("mid-reset pkt_count", {16'd0, pkt_count}, 32'd0);
    checkOutput("mid-reset S_TReady", {31'd0, S_TReady}, 32'd1);
    checkOutput("mid-reset queue empty", exp_q.size(), 32'd0);
    @(posedge CLK); #1;
    pkt[0] = 8'hFF;
    expectBeat(8'hFF, 1'b0); expectBeat(8'h01, 1'b1);
    applyStimulus(1, 1'b1);
    waitDrain("post-reset");
    checkOutput("pkt_count after post-reset", {16'd0, pkt_count}, 32'd1);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
